// File: rtl/eco_sig_accum.sv
// Clocked A/B-to-Y ECO cell: folds per-pair 3-bit results into a rotating
// signature over DEPTH samples, presented on a valid/ready output. Macro ECO_SIG_PARITY_EN adds sig_par.
module eco_sig_accum #(
   parameter int unsigned WIDTH = 5,
   parameter int unsigned DEPTH = 8,
   parameter int unsigned SIG_W = 16
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           clear,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               A,
   input  logic [WIDTH-1:0]               B,
   output logic [2:0]                     Y,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [SIG_W-1:0]               SIG,
`ifdef ECO_SIG_PARITY_EN
   output logic                           sig_par,
`endif
   output logic [$clog2(DEPTH+1)-1:0]     CNT
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]       state_q, state_d;
   logic [2:0]       y_q, y_d;
   logic [SIG_W-1:0] sig_q, sig_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [2:0]       y_c;
   logic             accept_c;
   logic             handshake_c;
   logic [SIG_W-1:0] base_sig_c;
   logic [CNT_W-1:0] base_cnt_c;
   logic [CNT_W-1:0] cnt_inc_c;

   // Per-sample reduction of the operand pair
   always_comb begin
      y_c[0] = ^(A & B);
      y_c[1] = (A == B);
      y_c[2] = (A > B);
   end

   assign out_valid   = (state_q == ST_HOLD);
   assign in_ready    = !clear && (!out_valid || out_ready);
   assign accept_c    = in_valid && in_ready;
   assign handshake_c = out_valid && out_ready;

   // A handover accept starts a fresh window instead of extending the held one
   assign base_sig_c = handshake_c ? '0 : sig_q;
   assign base_cnt_c = handshake_c ? '0 : cnt_q;
   assign cnt_inc_c  = base_cnt_c + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      y_d     = y_q;
      sig_d   = sig_q;
      cnt_d   = cnt_q;
      if (clear) begin
         sig_d   = '0;
         cnt_d   = '0;
         state_d = ST_ACCUM;
      end else if (accept_c) begin
         y_d     = y_c;
         sig_d   = {base_sig_c[SIG_W-2:0], base_sig_c[SIG_W-1]} ^ SIG_W'(y_c);
         cnt_d   = cnt_inc_c;
         state_d = (cnt_inc_c == CNT_W'(DEPTH)) ? ST_HOLD : ST_ACCUM;
      end else if (handshake_c) begin
         sig_d   = '0;
         cnt_d   = '0;
         state_d = ST_ACCUM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_ACCUM;
         y_q     <= '0;
         sig_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         y_q     <= y_d;
         sig_q   <= sig_d;
         cnt_q   <= cnt_d;
      end
   end

   assign Y   = y_q;
   assign SIG = sig_q;
   assign CNT = cnt_q;

`ifdef ECO_SIG_PARITY_EN
   logic sig_par_q;

   // Parity tracks the next signature so it moves on exactly the same edges
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_par_q <= 1'b0;
      end else begin
         sig_par_q <= ^sig_d;
      end
   end

   assign sig_par = sig_par_q;
`endif

endmodule
